uart_rx_control: RTL

- UART 8N1 receiver that deserialises the serial line driven by the team's ControlTransmiter.
- Sits on the FPGA side of the trading link: serial pin -> this block -> byte consumer (command parser / FIFO).
- Samples each bit at mid-bit and presents completed bytes on a one-entry valid/ready holding register.
- Flags framing errors and overrun.

---
 rtl/uart_pkg.sv | 9 +
 rtl/uart_rx_control_sync_2ff.sv | 23 ++
 rtl/uart_rx_control.sv | 111 +++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions for the control link: frame geometry and receiver states.
package uart_pkg;

    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    localparam logic [12:0] DEFAULT_CLKS_PER_BIT = 13'd868;
    localparam int          UART_DATA_BITS       = 8;

endpackage

// File: rtl/uart_rx_control_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit; reset value selects the idle level.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_p0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            meta_p0 <= RESET_VAL;
            q       <= RESET_VAL;
        end else begin
            meta_p0 <= d;
            q       <= meta_p0;
        end
    end

endmodule

// File: rtl/uart_rx_control.sv
// UART 8N1 receiver: mid-bit sampling, one-entry valid/ready holding register,
// framing-error pulse and sticky overrun flag.
module uart_rx_control
    import uart_pkg::*;
#(
    parameter logic [12:0] CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter logic [12:0] HALF_BIT     = CLKS_PER_BIT / 13'd2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rx_i,
    output logic [UART_DATA_BITS-1:0] data_o,
    output logic                      valid_o,
    input  logic                      ready_i,
    output logic                      frame_err_o,
    output logic                      overrun_o,
    output logic                      busy_o
);

    localparam int DATA_W = UART_DATA_BITS;

    rx_state_t         state;
    logic              rx_s;
    logic [12:0]       clk_cnt;
    logic [2:0]        bit_idx;
    logic [DATA_W-1:0] shift;
    logic              half_done;
    logic              bit_done;

    sync_2ff #(.RESET_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx_i),
        .q   (rx_s)
    );

    assign half_done = (clk_cnt == HALF_BIT - 13'd1);
    assign bit_done  = (clk_cnt == CLKS_PER_BIT - 13'd1);
    assign busy_o    = (state != RX_IDLE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= RX_IDLE;
            clk_cnt     <= '0;
            bit_idx     <= '0;
            shift       <= '0;
            data_o      <= '0;
            valid_o     <= 1'b0;
            frame_err_o <= 1'b0;
            overrun_o   <= 1'b0;
        end else begin
            frame_err_o <= 1'b0;
            // A load in RX_STOP below overrides this consume in the same cycle.
            if (valid_o && ready_i)
                valid_o <= 1'b0;

            case (state)
                RX_IDLE: begin
                    clk_cnt <= '0;
                    bit_idx <= '0;
                    if (!rx_s)
                        state <= RX_START;
                end
                RX_START: begin
                    if (half_done) begin
                        clk_cnt <= '0;
                        state   <= rx_s ? RX_IDLE : RX_DATA;
                    end else begin
                        clk_cnt <= clk_cnt + 13'd1;
                    end
                end
                RX_DATA: begin
                    if (bit_done) begin
                        clk_cnt        <= '0;
                        shift[bit_idx] <= rx_s;
                        if (bit_idx == 3'd7) begin
                            bit_idx <= '0;
                            state   <= RX_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 13'd1;
                    end
                end
                RX_STOP: begin
                    if (bit_done) begin
                        clk_cnt <= '0;
                        state   <= RX_IDLE;
                        if (!rx_s) begin
                            frame_err_o <= 1'b1;
                        end else if (!valid_o || ready_i) begin
                            data_o  <= shift;
                            valid_o <= 1'b1;
                        end else begin
                            overrun_o <= 1'b1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 13'd1;
                    end
                end
                default: begin
                    clk_cnt <= '0;
                    bit_idx <= '0;
                    state   <= RX_IDLE;
                end
            endcase
        end
    end

endmodule
